// File: rtl/mem_align_splitter_pkg.sv
// Purpose: shared widths, RISC-V load/store funct3 codes and FSM state encoding for mem_align_splitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_align_splitter_pkg;

    localparam int AddrWidth  = 32;
    localparam int DataWidth  = 32;
    localparam int Func3Width = 3;

    localparam logic [Func3Width-1:0] F3_B  = 3'd0;
    localparam logic [Func3Width-1:0] F3_H  = 3'd1;
    localparam logic [Func3Width-1:0] F3_W  = 3'd2;
    localparam logic [Func3Width-1:0] F3_BU = 3'd4;
    localparam logic [Func3Width-1:0] F3_HU = 3'd5;

    // Width selector for load_extend.
    localparam logic [1:0] WID_B = 2'd0;
    localparam logic [1:0] WID_H = 2'd1;
    localparam logic [1:0] WID_W = 2'd2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    function automatic logic f3_legal(input logic [Func3Width-1:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic f3_is_half(input logic [Func3Width-1:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/mem_align_splitter_load_extend.sv
// Purpose: final sign/zero extension of a reassembled load value.
// Latency: combinational, 0 cycles.
// Backpressure: none.
// Ports: i_width (0 byte, 1 half, 2 word), i_unsigned (zero-extend), i_raw (right-aligned bytes), o_data (extended).
module mem_align_splitter_load_extend
    import mem_align_splitter_pkg::*;
(
    input  logic [1:0]           i_width,
    input  logic                 i_unsigned,
    input  logic [DataWidth-1:0] i_raw,
    output logic [DataWidth-1:0] o_data
);

    logic w_sign_b;
    logic w_sign_h;

    assign w_sign_b = ~i_unsigned & i_raw[7];
    assign w_sign_h = ~i_unsigned & i_raw[15];

    always_comb begin
        o_data = i_raw;
        case (i_width)
            WID_B:   o_data = {{24{w_sign_b}}, i_raw[7:0]};
            WID_H:   o_data = {{16{w_sign_h}}, i_raw[15:0]};
            default: o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/mem_align_splitter.sv
// Purpose: passes in-word loads/stores straight to data memory; splits word-crossing ones into byte beats.
// Latency: aligned 0 extra cycles; split halfword 1 stall cycle, split word 3 stall cycles.
// Backpressure: asserts stall to freeze the pipeline while beats remain; flush/reset abort a split at once.
// Ports: req_* = MEM-stage access, mem_* = data memory side, stall/resp_* = pipeline side,
//        misaligned = crossing access seen with splitting disabled, flush/reset = abort.
module mem_align_splitter
    import mem_align_splitter_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1,
    parameter int ADDR_W   = AddrWidth,
    parameter int DATA_W   = DataWidth   // only 32 is supported
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_func3,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic                  flush,
    output logic                  mem_we,
    output logic [2:0]            mem_func3,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_data,
    output logic                  misaligned
);

    state_t              r_state;
    logic [1:0]          r_count;
    logic [23:0]         r_buf;
    logic                r_write;
    logic [2:0]          r_func3;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    state_t              w_state_nxt;
    logic [1:0]          w_count_nxt;
    logic [23:0]         w_buf_nxt;
    logic                w_latch;
    logic                w_need_split;
    logic                w_r_half;
    logic                w_last_beat;
    logic [7:0]          w_beat_wbyte;
    logic [DATA_W-1:0]   w_ext_raw;
    logic [DATA_W-1:0]   w_ext_data;

    // Halfword crosses only from offset 3; word crosses from any nonzero offset.
    assign w_need_split = req_valid &
        ((f3_is_half(req_func3) & (req_addr[1:0] == 2'd3)) |
         ((req_func3 == F3_W) & (req_addr[1:0] != 2'd0)));

    assign w_r_half    = f3_is_half(r_func3);
    assign w_last_beat = (r_count == (w_r_half ? 2'd1 : 2'd3));

    always_comb begin
        w_beat_wbyte = r_wdata[7:0];
        case (r_count)
            2'd0:    w_beat_wbyte = r_wdata[7:0];
            2'd1:    w_beat_wbyte = r_wdata[15:8];
            2'd2:    w_beat_wbyte = r_wdata[23:16];
            default: w_beat_wbyte = r_wdata[31:24];
        endcase
    end

    // Final beat's byte is read live from memory; earlier bytes come from the buffer.
    assign w_ext_raw = w_r_half ? {16'd0, mem_rdata[7:0], r_buf[7:0]}
                                : {mem_rdata[7:0], r_buf};

    mem_align_splitter_load_extend u_load_extend (
        .i_width    (w_r_half ? WID_H : WID_W),
        .i_unsigned (r_func3 == F3_HU),
        .i_raw      (w_ext_raw),
        .o_data     (w_ext_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_buf_nxt   = r_buf;
        w_latch     = 1'b0;
        mem_we      = 1'b0;
        mem_func3   = req_func3;
        mem_addr    = req_addr;
        mem_wdata   = req_wdata;
        stall       = 1'b0;
        resp_valid  = 1'b0;
        resp_data   = mem_rdata;
        misaligned  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_need_split) begin
                    if (SPLIT_EN) begin
                        // Beat 0 goes out straight from the request while it is latched.
                        mem_we      = req_write;
                        mem_func3   = req_write ? F3_B : F3_BU;
                        mem_wdata   = {{(DATA_W-8){1'b0}}, req_wdata[7:0]};
                        w_latch     = 1'b1;
                        w_buf_nxt   = {16'd0, mem_rdata[7:0]};
                        w_count_nxt = 2'd1;
                        w_state_nxt = ST_SPLIT;
                        stall       = 1'b1;
                    end else begin
                        misaligned  = 1'b1;
                    end
                end else if (req_valid && !f3_legal(req_func3)) begin
                    resp_valid = 1'b1;
                    resp_data  = '0;
                end else begin
                    mem_we     = req_valid & req_write;
                    resp_valid = req_valid;
                end
            end
            ST_SPLIT: begin
                mem_we    = r_write;
                mem_func3 = r_write ? F3_B : F3_BU;
                mem_addr  = r_addr + ADDR_W'(r_count);
                mem_wdata = {{(DATA_W-8){1'b0}}, w_beat_wbyte};
                if (w_last_beat) begin
                    resp_valid  = 1'b1;
                    resp_data   = w_ext_data;
                    w_count_nxt = 2'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    case (r_count)
                        2'd1:    w_buf_nxt[15:8]  = mem_rdata[7:0];
                        default: w_buf_nxt[23:16] = mem_rdata[7:0];
                    endcase
                    w_count_nxt = r_count + 2'd1;
                    stall       = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Abort wins over any request; bytes already stored stay written.
        if (reset || flush) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = 2'd0;
            w_buf_nxt   = '0;
            w_latch     = 1'b0;
            mem_we      = 1'b0;
            stall       = 1'b0;
            resp_valid  = 1'b0;
            misaligned  = 1'b0;
        end
        if (reset) begin
            mem_func3 = '0;
            mem_addr  = '0;
            mem_wdata = '0;
            resp_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= 2'd0;
            r_buf   <= '0;
            r_write <= 1'b0;
            r_func3 <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_buf   <= w_buf_nxt;
            if (w_latch) begin
                r_write <= req_write;
                r_func3 <= req_func3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_align_splitter.sv
module tb_mem_align_splitter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_valid0 = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_func3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        mem_clr = 1'b1;

    logic        mem_we, mem_we_0;
    logic [2:0]  mem_func3, mem_func3_0;
    logic [31:0] mem_addr, mem_addr_0, mem_wdata, mem_wdata_0;
    logic [31:0] mem_rdata, mem_rdata_0;
    logic        stall, stall_0, resp_valid, resp_valid_0, misaligned, misaligned_0;
    logic [31:0] resp_data, resp_data_0;

    logic [7:0]  mem1    [0:4095];
    logic [7:0]  mem0    [0:4095];
    logic [7:0]  ref_mem [0:4095];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_align_splitter #(.SPLIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .mem_we(mem_we), .mem_func3(mem_func3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall), .resp_valid(resp_valid), .resp_data(resp_data),
        .misaligned(misaligned)
    );

    mem_align_splitter #(.SPLIT_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_write(req_write),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .mem_we(mem_we_0), .mem_func3(mem_func3_0), .mem_addr(mem_addr_0), .mem_wdata(mem_wdata_0),
        .mem_rdata(mem_rdata_0), .stall(stall_0), .resp_valid(resp_valid_0), .resp_data(resp_data_0),
        .misaligned(misaligned_0)
    );

    // Byte count moved by a memory access of the given funct3.
    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [11:0] ridx(input logic [31:0] a, input int i);
        logic [31:0] s;
        s = a + 32'(i);
        return s[11:0];
    endfunction

    // Data-memory read behaviour: extension done by the memory itself.
    function automatic logic [31:0] mem_fmt(input logic [31:0] w, input logic [2:0] f3);
        case (f3)
            3'd0:    return {{24{w[7]}}, w[7:0]};
            3'd4:    return {24'd0, w[7:0]};
            3'd1:    return {{16{w[15]}}, w[15:0]};
            3'd5:    return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always_comb begin
        mem_rdata   = mem_fmt({mem1[ridx(mem_addr, 3)], mem1[ridx(mem_addr, 2)],
                               mem1[ridx(mem_addr, 1)], mem1[ridx(mem_addr, 0)]}, mem_func3);
        mem_rdata_0 = mem_fmt({mem0[ridx(mem_addr_0, 3)], mem0[ridx(mem_addr_0, 2)],
                               mem0[ridx(mem_addr_0, 1)], mem0[ridx(mem_addr_0, 0)]}, mem_func3_0);
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) begin
                mem1[i] <= 8'd0;
                mem0[i] <= 8'd0;
            end
        end else begin
            if (mem_we)
                for (int i = 0; i < size_of(mem_func3); i++)
                    mem1[ridx(mem_addr, i)] <= mem_wdata[8*i +: 8];
            if (mem_we_0)
                for (int j = 0; j < size_of(mem_func3_0); j++)
                    mem0[ridx(mem_addr_0, j)] <= mem_wdata_0[8*j +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] win1(input logic [31:0] a);
        return {mem1[ridx(a, 3)], mem1[ridx(a, 2)], mem1[ridx(a, 1)], mem1[ridx(a, 0)]};
    endfunction

    function automatic logic [31:0] win_ref(input logic [31:0] a);
        return {ref_mem[ridx(a, 3)], ref_mem[ridx(a, 2)], ref_mem[ridx(a, 1)], ref_mem[ridx(a, 0)]};
    endfunction

    // One complete access on the SPLIT_EN=1 instance, checked against the reference memory.
    task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
        int sz, exp_st, stalls, resps;
        bit legal;
        logic [31:0] exp_d, got;
        logic mis;
        legal  = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        sz     = size_of(f3);
        exp_st = (legal && (int'(a[1:0]) + sz > 4)) ? sz - 1 : 0;
        exp_d  = 32'd0;
        if (legal && !wr) begin
            for (int i = 0; i < sz; i++) exp_d[8*i +: 8] = ref_mem[ridx(a, i)];
            if (f3 == 3'd0 && exp_d[7])  exp_d = exp_d | 32'hFFFFFF00;
            if (f3 == 3'd1 && exp_d[15]) exp_d = exp_d | 32'hFFFF0000;
        end
        req_valid = 1'b1; req_write = wr; req_func3 = f3; req_addr = a; req_wdata = wd;
        stalls = 0; resps = 0; got = 32'd0; mis = 1'b0;
        for (int c = 0; c < 8 && resps == 0; c++) begin
            #4;
            if (stall) stalls++;
            mis |= misaligned;
            if (resp_valid) begin resps++; got = resp_data; end
            @(posedge clk); #1;
            if (resps == 0) begin
                // Upstream wiggles while stalled must not matter.
                req_write = 1'($urandom); req_func3 = 3'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end
        end
        req_valid = 1'b0;
        #4;
        check({tag, "_idle_after"}, {30'd0, stall, resp_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_stalls"}, stalls, exp_st);
        check({tag, "_resp_cnt"}, resps, 1);
        check({tag, "_misaligned"}, {31'd0, mis}, 32'd0);
        if (!(legal && wr)) check({tag, "_data"}, got, exp_d);
        if (legal && wr)
            for (int i = 0; i < sz; i++) ref_mem[ridx(a, i)] = wd[8*i +: 8];
        check({tag, "_mem"}, win1(a), win_ref(a));
    endtask

    logic [2:0] f3tab [0:12] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1,
                                 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    initial begin
        logic [31:0] a, d;
        logic [2:0]  f3;
        logic        wr;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;

        // Reset: all outputs forced low even with a request present.
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_func3 = 3'd2; req_addr = 32'h0000_0123; req_wdata = $urandom;
        #4;
        check("rst_ctl", {27'd0, mem_we, mem_func3, stall, resp_valid}, 32'd0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata", resp_data, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; reset = 1'b0; mem_clr = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, "sw_al");
        access(1'b0, 3'd2, 32'h100, 32'd0, "lw_al");
        access(1'b1, 3'd1, 32'h201, 32'h0000_8001, "sh_mid");
        access(1'b0, 3'd1, 32'h201, 32'd0, "lh_mid");
        access(1'b1, 3'd1, 32'h303, 32'h1234_A55A, "sh_split");
        check("sh_split_b0", {24'd0, mem1[12'h303]}, 32'h5A);
        check("sh_split_b1", {24'd0, mem1[12'h304]}, 32'hA5);
        access(1'b0, 3'd5, 32'h303, 32'd0, "lhu_split");
        access(1'b0, 3'd1, 32'h303, 32'd0, "lh_split");
        access(1'b1, 3'd2, 32'h401, 32'h11223344, "sw_split");
        access(1'b0, 3'd2, 32'h401, 32'd0, "lw_split");
        access(1'b1, 3'd2, 32'hFFFF_FFFE, 32'hCAFE_BABE, "sw_wrap");
        access(1'b0, 3'd2, 32'hFFFF_FFFE, 32'd0, "lw_wrap");
        access(1'b1, 3'd2, 32'h500, 32'h600D_F00D, "sw_500");
        access(1'b0, 3'd3, 32'h100, 32'd0, "ld_illegal");

        // Flush during beat 2 of a split load.
        req_valid = 1'b1; req_write = 1'b0; req_func3 = 3'd2; req_addr = 32'h502;
        #4 check("fl_beat0_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        #4 check("fl_ctl", {29'd0, stall, resp_valid, mem_we}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        #4 check("fl_idle", {30'd0, stall, resp_valid}, 32'd0);
        @(posedge clk); #1;
        access(1'b0, 3'd2, 32'h500, 32'd0, "lw_after_fl");

        // Flush during beat 1 of a split store: beat 0 stays written, the rest does not.
        req_valid = 1'b1; req_write = 1'b1; req_func3 = 3'd2; req_addr = 32'h581; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        ref_mem[12'h581] = 8'h0D;
        flush = 1'b1;
        #4 check("fls_ctl", {29'd0, stall, resp_valid, mem_we}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        check("fls_mem", win1(32'h581), win_ref(32'h581));

        // Splitting disabled: crossing store is suppressed and flagged.
        req_valid0 = 1'b1; req_write = 1'b1; req_func3 = 3'd2; req_addr = 32'h601; req_wdata = 32'h89ABCDEF;
        #4;
        check("nosplit_mis", {31'd0, misaligned_0}, 32'd1);
        check("nosplit_ctl", {29'd0, mem_we_0, resp_valid_0, stall_0}, 32'd0);
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        @(posedge clk); #1;
        check("nosplit_mem", {mem0[12'h604], mem0[12'h603], mem0[12'h602], mem0[12'h601]}, 32'd0);

        // Reset in the middle of a split load.
        req_valid = 1'b1; req_write = 1'b0; req_func3 = 3'd2; req_addr = 32'h702;
        @(posedge clk); #1;
        reset = 1'b1;
        #4;
        check("rsm_ctl", {27'd0, mem_we, mem_func3, stall, resp_valid}, 32'd0);
        check("rsm_addr", mem_addr, 32'd0);
        check("rsm_data", resp_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        #4 check("rsm_idle", {29'd0, stall, resp_valid, mem_we}, 32'd0);
        @(posedge clk); #1;
        access(1'b0, 3'd2, 32'h100, 32'd0, "lw_after_rst");

        // Randomized accesses against the reference memory.
        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom);
            f3 = f3tab[$urandom_range(0, 12)];
            if (wr && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
            a = $urandom;
            d = $urandom;
            access(wr, f3, a, d, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
